uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
- Boot-time controller that holds the fib core in reset and fills instruction memory from bytes received over the UART.
- A length-prefixed image is written word-by-word into imem. The loader then sends an ACK byte through the buffered UART transmitter and releases the core.
- Sits between the UART receiver, the instruction memory write port, the UART TX buffer input, and the core's reset.

Parameters:
- ADDR_W, 10, imem word-address width; capacity 2**ADDR_W words.
- TIMEOUT, 1000000, maximum idle cycles between bytes inside a transfer before abort.
- ACK_BYTE, 8'hAA, byte sent on successful load.
- NAK_BYTE, 8'hEE, byte sent on error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only with rx_valid.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_full  in  1  UART TX buffer cannot accept a byte.
- tx_data  out  8  byte to transmit.
- tx_ready  out  1  one-cycle push strobe into the UART TX buffer.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  word to write.
- core_rst  out  1  active-high reset to core; 1 until the load completes.
- loading  out  1  high in LEN and DATA.
- err  out  1  sticky error flag.

Behaviour:
- Reset values (at the clock edge with rst=1): state IDLE, core_rst=1, every other output 0, all counters 0. The same applies when rst asserts in any state, including mid-DATA.
- States: IDLE, LEN, DATA, ACK, NAK, RUN.
- IDLE:
  - rx_valid -> take the byte as length byte 0, clear err, go to LEN.
- LEN:
  - Collect bytes 1..3 of the 32-bit word count N, little-endian.
  - After byte 3, if N > 2**ADDR_W -> NAK.
  - If N == 0 -> ACK.
  - Otherwise -> DATA, with word index 0.
- DATA:
  - Byte k (0..3) of each word goes to bits [8k+7:8k] (little-endian).
  - On the cycle after the rx_valid carrying byte 3: imem_we=1 for exactly one cycle, imem_addr = word index, imem_wdata = assembled word.
  - The word index then increments. After word N-1 is written -> ACK.
  - imem_addr and imem_wdata are don't-care while imem_we=0.
- Timeout:
  - Counter clears on every rx_valid and on entry to LEN.
  - In LEN or DATA, reaching TIMEOUT consecutive cycles with no rx_valid -> NAK.
  - If rx_valid and the timeout fall in the same cycle, the byte wins and the counter clears.
- ACK:
  - Wait while tx_full=1. On the first cycle with tx_full=0: tx_ready=1, tx_data=ACK_BYTE for one cycle.
  - Next cycle -> RUN.
- NAK:
  - Same handshake as ACK, using NAK_BYTE. Set err=1, then go to IDLE with core_rst still 1.
  - err stays 1 until the next IDLE->LEN transition or rst.
- RUN:
  - core_rst=0. All rx_valid ignored; the UART belongs to the core. Leave RUN only via rst.
- rx_valid in ACK or NAK is dropped.
- tx_ready is never asserted in any state other than ACK or NAK, and never more than once per visit.
- Exactly N imem_we pulses per successful load, and none on an error path after the last completed word.
- Counters: byte index 2 bits, word index ADDR_W+1 bits, timeout counter wide enough for TIMEOUT. No wrap is possible because N ≤ 2**ADDR_W.

Test Plan:
- Good load, N=2: send bytes 02 00 00 00, 13 00 00 00, 93 00 A0 00.
  - Writes 0x00000013 at address 0 and 0x00A00093 at address 1, one cycle after each 4th byte.
  - tx_ready pulses once with 0xAA, then core_rst falls to 0 and stays 0.
- N=0: send 00 00 00 00 -> no imem_we; 0xAA sent; core_rst=0.
- Oversize, ADDR_W=10: send 01 04 00 00 (N=1025).
  - No imem_we; 0xEE sent; err=1; state IDLE; core_rst=1.
  - A following valid N=1 load writes address 0, clears err on its first byte, and ends with 0xAA.
- Timeout: send length 01 00 00 00, then bytes 11 22, then no bytes for TIMEOUT cycles.
  - 0xEE sent on the timeout cycle; no imem_we; err=1.
  - Repeat with a byte arriving on exactly the timeout cycle -> no abort.
- Backpressure: hold tx_full=1 for 50 cycles at ACK time.
  - tx_ready stays 0 and core_rst stays 1 throughout.
  - tx_ready pulses once on the first cycle after tx_full falls.
- Reset mid-load: assert rst for one cycle after 5 data bytes.
  - All outputs return to reset values.
  - A fresh N=1 load writes address 0 with the new data.

Source files
------------

// File: rtl/uart_program_loader_if.sv
// Byte-stream, TX-push and imem-write signals shared by the loader and its neighbours.
// The loader side is the master: it consumes rx/tx_full and drives tx and imem.
`timescale 1ns/1ps
interface uart_program_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              tx_full;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid, tx_full,
    output tx_data, tx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_full,
    input  tx_data, tx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: fills imem from a length-prefixed UART image, replies ACK/NAK, then releases core_rst.
// imem write one cycle after each 4th byte; the reply byte waits while tx_full is high, then pushes once.
`timescale 1ns/1ps
module uart_program_loader #(
  parameter int         ADDR_W   = 10,
  parameter int         TIMEOUT  = 1000000,
  parameter logic [7:0] ACK_BYTE = 8'hAA,
  parameter logic [7:0] NAK_BYTE = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_program_loader_if.master bus,
  output logic                  core_rst,
  output logic                  loading,
  output logic                  err
);

  localparam int          TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [32:0] CAP      = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, LEN, DATA, ACK, NAK, RUN} state_t;

  state_t            state;
  logic [1:0]        byte_idx;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   n_words;
  logic [TMO_W-1:0]  tmo;
  logic [23:0]       asm_buf;
  logic              sent;
  logic [31:0]       len_full;

  // The current byte completes either the length word or a data word.
  assign len_full = {bus.rx_data, asm_buf};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      byte_idx       <= '0;
      word_idx       <= '0;
      n_words        <= '0;
      tmo            <= '0;
      asm_buf        <= '0;
      sent           <= 1'b0;
      core_rst       <= 1'b1;
      loading        <= 1'b0;
      err            <= 1'b0;
      bus.tx_data    <= '0;
      bus.tx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.tx_ready <= 1'b0;
      bus.imem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            asm_buf  <= {16'h0000, bus.rx_data};
            byte_idx <= 2'd1;
            tmo      <= '0;
            err      <= 1'b0;
            loading  <= 1'b1;
            state    <= LEN;
          end
        end

        LEN, DATA: begin
          if (bus.rx_valid) begin
            tmo      <= '0;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_buf[7:0]   <= bus.rx_data;
              2'd1: asm_buf[15:8]  <= bus.rx_data;
              2'd2: asm_buf[23:16] <= bus.rx_data;
              default: begin
                if (state == LEN) begin
                  if ({1'b0, len_full} > CAP) begin
                    state   <= NAK;
                    err     <= 1'b1;
                    loading <= 1'b0;
                  end else if (len_full == 32'd0) begin
                    state   <= ACK;
                    loading <= 1'b0;
                  end else begin
                    state    <= DATA;
                    n_words  <= len_full[ADDR_W:0];
                    word_idx <= '0;
                  end
                end else begin
                  bus.imem_we    <= 1'b1;
                  bus.imem_addr  <= word_idx[ADDR_W-1:0];
                  bus.imem_wdata <= len_full;
                  word_idx       <= word_idx + 1'b1;
                  if (word_idx == n_words - 1'b1) begin
                    state   <= ACK;
                    loading <= 1'b0;
                  end
                end
              end
            endcase
          end else if (tmo == TMO_LAST) begin
            state   <= NAK;
            err     <= 1'b1;
            loading <= 1'b0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        ACK: begin
          if (sent) begin
            sent     <= 1'b0;
            core_rst <= 1'b0;
            state    <= RUN;
          end else if (!bus.tx_full) begin
            bus.tx_ready <= 1'b1;
            bus.tx_data  <= ACK_BYTE;
            sent         <= 1'b1;
          end
        end

        NAK: begin
          if (sent) begin
            sent  <= 1'b0;
            state <= IDLE;
          end else if (!bus.tx_full) begin
            bus.tx_ready <= 1'b1;
            bus.tx_data  <= NAK_BYTE;
            sent         <= 1'b1;
          end
        end

        RUN: begin
          // The UART now belongs to the core; only rst leaves this state.
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: drives byte streams and checks writes, replies and flags.
`timescale 1ns/1ps
module tb_uart_program_loader;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst;
  logic core_rst, loading, err;

  uart_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_program_loader #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT),
    .ACK_BYTE(8'hAA),
    .NAK_BYTE(8'hEE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .core_rst(core_rst),
    .loading (loading),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_cyc;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  logic [31:0] tq_data[$];
  int          tq_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      wq_addr.push_back(32'(bus.imem_addr));
      wq_data.push_back(bus.imem_wdata);
      wq_cyc.push_back(cyc);
    end
    if (bus.tx_ready) begin
      tq_data.push_back(32'(bus.tx_data));
      tq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    tq_data.delete(); tq_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    check({tag, "_loading"},  32'(loading), 32'd0);
    check({tag, "_err"},      32'(err), 32'd0);
    check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd0);
    check({tag, "_tx_data"},  32'(bus.tx_data), 32'd0);
    check({tag, "_imem_we"},  32'(bus.imem_we), 32'd0);
    check({tag, "_addr"},     32'(bus.imem_addr), 32'd0);
    check({tag, "_wdata"},    bus.imem_wdata, 32'd0);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input string tag, input int max);
    for (int i = 0; i < max && tq_data.size() == 0; i++) @(posedge clk);
    #1;
    check({tag, "_tx_seen"}, 32'(tq_data.size() != 0), 32'd1);
  endtask

  int w0, w1, f, bad;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_full = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    check_reset("rst0");

    // Good load, N=2
    send(8'h02);
    check("t1_loading", 32'(loading), 32'd1);
    send(8'h00); send(8'h00); send(8'h00);
    send_word(32'h0000_0013); w0 = last_cyc;
    send_word(32'h00A0_0093); w1 = last_cyc;
    idle(1);
    check("t1_nwr", 32'(wq_data.size()), 32'd2);
    if (wq_data.size() == 2) begin
      check("t1_addr0", wq_addr[0], 32'd0);
      check("t1_data0", wq_data[0], 32'h0000_0013);
      check("t1_lat0",  32'(wq_cyc[0]), 32'(w0));
      check("t1_addr1", wq_addr[1], 32'd1);
      check("t1_data1", wq_data[1], 32'h00A0_0093);
      check("t1_lat1",  32'(wq_cyc[1]), 32'(w1));
    end
    wait_tx("t1", 10);
    idle(5);
    check("t1_ntx", 32'(tq_data.size()), 32'd1);
    if (tq_data.size() != 0) begin
      check("t1_ack", tq_data[0], 32'hAA);
      check("t1_ack_cyc", 32'(tq_cyc[0]), 32'(w1 + 1));
    end
    check("t1_core_rst", 32'(core_rst), 32'd0);
    check("t1_loading_end", 32'(loading), 32'd0);
    send(8'h55); send(8'h01); idle(3);
    check("t1_run_nwr", 32'(wq_data.size()), 32'd2);
    check("t1_run_ntx", 32'(tq_data.size()), 32'd1);
    check("t1_run_core_rst", 32'(core_rst), 32'd0);

    // N=0
    do_reset();
    send_word(32'd0);
    idle(5);
    check("t2_nwr", 32'(wq_data.size()), 32'd0);
    check("t2_ntx", 32'(tq_data.size()), 32'd1);
    if (tq_data.size() != 0) check("t2_ack", tq_data[0], 32'hAA);
    check("t2_core_rst", 32'(core_rst), 32'd0);

    // Oversize N=1025, then a valid N=1 load
    do_reset();
    send_word(32'h0000_0401);
    idle(6);
    check("t3_nwr", 32'(wq_data.size()), 32'd0);
    check("t3_ntx", 32'(tq_data.size()), 32'd1);
    if (tq_data.size() != 0) check("t3_nak", tq_data[0], 32'hEE);
    check("t3_err", 32'(err), 32'd1);
    check("t3_core_rst", 32'(core_rst), 32'd1);
    check("t3_loading", 32'(loading), 32'd0);
    send(8'h01);
    check("t3_err_clr", 32'(err), 32'd0);
    check("t3_loading2", 32'(loading), 32'd1);
    send(8'h00); send(8'h00); send(8'h00);
    send_word(32'hCAFE_F00D);
    idle(5);
    check("t3_nwr2", 32'(wq_data.size()), 32'd1);
    if (wq_data.size() != 0) begin
      check("t3_addr", wq_addr[0], 32'd0);
      check("t3_data", wq_data[0], 32'hCAFE_F00D);
    end
    check("t3_ntx2", 32'(tq_data.size()), 32'd2);
    if (tq_data.size() == 2) check("t3_ack", tq_data[1], 32'hAA);
    check("t3_core_rst2", 32'(core_rst), 32'd0);

    // Timeout after two data bytes
    do_reset();
    send_word(32'd1); send(8'h11); send(8'h22);
    w0 = last_cyc;
    idle(TIMEOUT + 5);
    check("t4_ntx", 32'(tq_data.size()), 32'd1);
    if (tq_data.size() != 0) begin
      check("t4_nak", tq_data[0], 32'hEE);
      check("t4_nak_cyc", 32'(tq_cyc[0]), 32'(w0 + TIMEOUT + 1));
    end
    check("t4_nwr", 32'(wq_data.size()), 32'd0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_core_rst", 32'(core_rst), 32'd1);

    // Byte lands exactly on the timeout cycle: no abort
    do_reset();
    send_word(32'd1); send(8'h11); send(8'h22);
    idle(TIMEOUT - 1);
    send(8'h33); send(8'h44);
    idle(5);
    check("t5_ntx", 32'(tq_data.size()), 32'd1);
    if (tq_data.size() != 0) check("t5_ack", tq_data[0], 32'hAA);
    check("t5_nwr", 32'(wq_data.size()), 32'd1);
    if (wq_data.size() != 0) check("t5_data", wq_data[0], 32'h4433_2211);
    check("t5_err", 32'(err), 32'd0);

    // Backpressure at ACK time
    do_reset();
    bus.tx_full = 1'b1;
    send_word(32'd1); send_word(32'h1234_5678);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_ready || !core_rst) bad++;
    end
    check("t6_hold", 32'(bad), 32'd0);
    @(posedge clk); #1;
    bus.tx_full = 1'b0;
    f = cyc;
    wait_tx("t6", 10);
    idle(3);
    check("t6_ntx", 32'(tq_data.size()), 32'd1);
    if (tq_data.size() != 0) begin
      check("t6_ack", tq_data[0], 32'hAA);
      check("t6_ack_cyc", 32'(tq_cyc[0]), 32'(f + 1));
    end
    check("t6_core_rst", 32'(core_rst), 32'd0);
    check("t6_nwr", 32'(wq_data.size()), 32'd1);

    // Reset in the middle of DATA, then a fresh load
    do_reset();
    send_word(32'd2); send_word(32'h0403_0201); send(8'h05);
    check("t7_loading", 32'(loading), 32'd1);
    do_reset();
    check_reset("t7_rst");
    send_word(32'd1); send_word(32'hDEAD_BEEF);
    idle(5);
    check("t7_nwr", 32'(wq_data.size()), 32'd1);
    if (wq_data.size() != 0) begin
      check("t7_addr", wq_addr[0], 32'd0);
      check("t7_data", wq_data[0], 32'hDEAD_BEEF);
    end
    check("t7_ntx", 32'(tq_data.size()), 32'd1);
    if (tq_data.size() != 0) check("t7_ack", tq_data[0], 32'hAA);
    check("t7_core_rst", 32'(core_rst), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
